// File: rtl/branch_target_predictor.sv
// Successor branch predictor: tagged direct-mapped BTB plus a saturating-counter PHT with optional gshare.
// IF lookup is combinational off registered state; Mem resolution trains the tables and flags mispredicts.

module branch_target_predictor_pht_ctr #(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  output logic [CTR_W-1:0] ctr
);
  // Reset to weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

  always_ff @(posedge clk) begin
    if (!rst_n)                         ctr <= CTR_INIT;
    else if (en &&  up && (ctr != '1))  ctr <= ctr + CTR_W'(1);
    else if (en && !up && (ctr != '0))  ctr <= ctr - CTR_W'(1);
  end
endmodule

module branch_target_predictor #(
  parameter int ADDR_W      = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int PHT_ENTRIES = 256,
  parameter int CTR_W       = 2,
  parameter int GSHARE      = 1,
  parameter int GHR_W       = 8,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] PC_Addr_IF,
  output logic              BranchPredict_IF,
  output logic [ADDR_W-1:0] Target_Addr_IF,
  output logic [GHR_W-1:0]  GHR_IF,
  input  logic              Branch_Valid_Mem,
  input  logic [ADDR_W-1:0] PC_Addr_Mem,
  input  logic              BranchCtr_Mem,
  input  logic              BranchPredict_Mem,
  input  logic [ADDR_W-1:0] Pred_Target_Mem,
  input  logic [ADDR_W-1:0] Target_Addr_Mem,
  input  logic [GHR_W-1:0]  GHR_Mem,
  output logic              BranchPredict_fault,
  output logic [ADDR_W-1:0] Redirect_Addr,
  output logic [CNT_W-1:0]  Branch_Count,
  output logic [CNT_W-1:0]  Mispredict_Count
);
  localparam int BIDX_W = $clog2(BTB_ENTRIES);
  localparam int PIDX_W = $clog2(PHT_ENTRIES);
  localparam int TAG_W  = ADDR_W - BIDX_W - 2;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
  } btb_data_t;

  typedef struct packed {
    logic              valid;
    logic              taken;
    logic [BIDX_W-1:0] bidx;
    logic [PIDX_W-1:0] pidx;
    btb_data_t         entry;
  } train_req_t;

  logic [BTB_ENTRIES-1:0]            btb_valid;
  btb_data_t                         btb_data [BTB_ENTRIES];
  logic [PHT_ENTRIES-1:0][CTR_W-1:0] pht;
  logic [GHR_W-1:0]                  ghr;

  logic [BIDX_W-1:0] if_bidx;
  logic [TAG_W-1:0]  if_tag;
  logic [PIDX_W-1:0] if_pidx;
  logic              if_hit;
  logic [ADDR_W-1:0] resolved_next;
  train_req_t        train;

  // IF lookup: ghr is held at zero when gshare is disabled, so the xor is harmless.
  assign if_bidx = PC_Addr_IF[BIDX_W+1:2];
  assign if_tag  = PC_Addr_IF[ADDR_W-1:BIDX_W+2];
  assign if_pidx = PC_Addr_IF[PIDX_W+1:2] ^ PIDX_W'(ghr);
  assign if_hit  = btb_valid[if_bidx] && (btb_data[if_bidx].tag == if_tag);

  assign BranchPredict_IF = if_hit && pht[if_pidx][CTR_W-1];
  assign Target_Addr_IF   = BranchPredict_IF ? btb_data[if_bidx].target : PC_Addr_IF + ADDR_W'(4);
  assign GHR_IF           = ghr;

  // Mispredict detection depends only on Mem-stage inputs; a wrong taken target is also a fault.
  assign resolved_next       = BranchCtr_Mem ? Target_Addr_Mem : PC_Addr_Mem + ADDR_W'(4);
  assign BranchPredict_fault = Branch_Valid_Mem &&
                               ((BranchCtr_Mem != BranchPredict_Mem) ||
                                (BranchCtr_Mem && (Pred_Target_Mem != Target_Addr_Mem)));
  assign Redirect_Addr       = BranchPredict_fault ? resolved_next : '0;

  // Training uses the history captured at fetch time, not the live GHR.
  always_comb begin
    train              = '0;
    train.valid        = Branch_Valid_Mem;
    train.taken        = BranchCtr_Mem;
    train.bidx         = PC_Addr_Mem[BIDX_W+1:2];
    train.pidx         = PC_Addr_Mem[PIDX_W+1:2] ^ ((GSHARE != 0) ? PIDX_W'(GHR_Mem) : '0);
    train.entry.tag    = PC_Addr_Mem[ADDR_W-1:BIDX_W+2];
    train.entry.target = Target_Addr_Mem;
  end

  for (genvar i = 0; i < PHT_ENTRIES; i++) begin : g_pht
    branch_target_predictor_pht_ctr #(.CTR_W(CTR_W)) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (train.valid && (train.pidx == PIDX_W'(i))),
      .up    (train.taken),
      .ctr   (pht[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                          btb_valid <= '0;
    else if (train.valid && train.taken) btb_valid[train.bidx] <= 1'b1;
  end

  // Tag/target storage needs no reset; the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (rst_n && train.valid && train.taken) btb_data[train.bidx] <= train.entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                           ghr <= '0;
    else if ((GSHARE != 0) && train.valid) ghr <= GHR_W'({ghr, train.taken});
  end

  // Performance counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Branch_Count     <= '0;
      Mispredict_Count <= '0;
    end else if (train.valid) begin
      if (Branch_Count != '1)
        Branch_Count <= Branch_Count + CNT_W'(1);
      if (BranchPredict_fault && (Mispredict_Count != '1))
        Mispredict_Count <= Mispredict_Count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: a plain (non-gshare, 4-bit counters) and a gshare instance
// share stimulus and are checked every cycle against an array-based reference model.

module tb_branch_target_predictor;
  localparam int BE = 64;
  localparam int PE = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if, mem_pc, ptgt, tgt;
  logic        br_valid, taken, pred_mem;
  logic [7:0]  ghr_mem;

  logic        bp_n, bp_g, fault_n, fault_g;
  logic [31:0] ta_n, ta_g, redir_n, redir_g;
  logic [7:0]  ghr_n, ghr_g;
  logic [3:0]  bc_n, mc_n;
  logic [31:0] bc_g, mc_g;

  always #5 clk = ~clk;

  branch_target_predictor #(.GSHARE(0), .CNT_W(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .PC_Addr_IF(pc_if), .BranchPredict_IF(bp_n),
    .Target_Addr_IF(ta_n), .GHR_IF(ghr_n), .Branch_Valid_Mem(br_valid), .PC_Addr_Mem(mem_pc),
    .BranchCtr_Mem(taken), .BranchPredict_Mem(pred_mem), .Pred_Target_Mem(ptgt),
    .Target_Addr_Mem(tgt), .GHR_Mem(ghr_mem), .BranchPredict_fault(fault_n),
    .Redirect_Addr(redir_n), .Branch_Count(bc_n), .Mispredict_Count(mc_n));

  branch_target_predictor dut_g (
    .clk(clk), .rst_n(rst_n), .PC_Addr_IF(pc_if), .BranchPredict_IF(bp_g),
    .Target_Addr_IF(ta_g), .GHR_IF(ghr_g), .Branch_Valid_Mem(br_valid), .PC_Addr_Mem(mem_pc),
    .BranchCtr_Mem(taken), .BranchPredict_Mem(pred_mem), .Pred_Target_Mem(ptgt),
    .Target_Addr_Mem(tgt), .GHR_Mem(ghr_mem), .BranchPredict_fault(fault_g),
    .Redirect_Addr(redir_g), .Branch_Count(bc_g), .Mispredict_Count(mc_g));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model; index 0 = plain instance, 1 = gshare instance.
  bit          m_valid [2][BE];
  logic [31:0] m_tag   [2][BE];
  logic [31:0] m_tgt   [2][BE];
  int          m_ctr   [2][PE];
  int unsigned m_ghr   [2];
  longint      m_bc    [2];
  longint      m_mc    [2];

  function automatic longint cnt_max(int g);
    return (g == 0) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < BE; i++) m_valid[g][i] = 1'b0;
      for (int i = 0; i < PE; i++) m_ctr[g][i] = 1;
      m_ghr[g] = 0; m_bc[g] = 0; m_mc[g] = 0;
    end
  endtask

  task automatic m_lookup(input int g, input logic [31:0] pc, output logic p, output logic [31:0] t);
    int b, x;
    bit hit;
    b   = int'((pc >> 2) % BE);
    x   = int'((pc >> 2) % PE) ^ ((g == 1) ? int'(m_ghr[1]) : 0);
    hit = m_valid[g][b] && (m_tag[g][b] == (pc >> 8));
    p   = hit && (m_ctr[g][x] >= 2);
    t   = p ? m_tgt[g][b] : pc + 32'd4;
  endtask

  function automatic bit m_fault();
    return br_valid && ((taken != pred_mem) || (taken && (ptgt != tgt)));
  endfunction

  task automatic model_update();
    bit f;
    int b, x;
    f = m_fault();
    if (!rst_n) begin model_reset(); return; end
    if (!br_valid) return;
    for (int g = 0; g < 2; g++) begin
      b = int'((mem_pc >> 2) % BE);
      x = int'((mem_pc >> 2) % PE) ^ ((g == 1) ? int'(ghr_mem) : 0);
      if (taken) m_ctr[g][x] = (m_ctr[g][x] < 3) ? m_ctr[g][x] + 1 : 3;
      else       m_ctr[g][x] = (m_ctr[g][x] > 0) ? m_ctr[g][x] - 1 : 0;
      if (taken) begin
        m_valid[g][b] = 1'b1; m_tag[g][b] = mem_pc >> 8; m_tgt[g][b] = tgt;
      end
      if (g == 1) m_ghr[g] = ((m_ghr[g] << 1) | 32'(taken)) & 32'hFF;
      if (m_bc[g] < cnt_max(g)) m_bc[g]++;
      if (f && (m_mc[g] < cnt_max(g))) m_mc[g]++;
    end
  endtask

  task automatic check_all();
    logic p; logic [31:0] t, r; bit f;
    f = m_fault();
    r = f ? (taken ? tgt : mem_pc + 32'd4) : 32'd0;
    m_lookup(0, pc_if, p, t);
    chk("pred_n", bp_n, p); chk("tgt_n", ta_n, t); chk("ghr_n", ghr_n, m_ghr[0]);
    m_lookup(1, pc_if, p, t);
    chk("pred_g", bp_g, p); chk("tgt_g", ta_g, t); chk("ghr_g", ghr_g, m_ghr[1]);
    chk("fault_n", fault_n, f); chk("redir_n", redir_n, r);
    chk("fault_g", fault_g, f); chk("redir_g", redir_g, r);
    chk("bc_n", bc_n, m_bc[0]); chk("mc_n", mc_n, m_mc[0]);
    chk("bc_g", bc_g, m_bc[1]); chk("mc_g", mc_g, m_mc[1]);
  endtask

  task automatic step();
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    #3;
    step();
  endtask

  task automatic set_idle();
    br_valid = 0; mem_pc = 0; taken = 0; pred_mem = 0; ptgt = 0; tgt = 0; ghr_mem = 0;
  endtask

  task automatic res(input logic [31:0] pc, input bit tk, input bit pr,
                     input logic [31:0] pt, input logic [31:0] tg);
    br_valid = 1; mem_pc = pc; taken = tk; pred_mem = pr; ptgt = pt; tgt = tg;
    ghr_mem = m_ghr[1][7:0];
  endtask

  task automatic do_reset();
    rst_n = 0; set_idle(); #3;
    @(posedge clk); model_update(); #1;
    rst_n = 1;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 23)) << 2) | ($urandom_range(0, 1) != 0 ? 32'h0001_0000 : 32'h0);
  endfunction

  function automatic logic [31:0] pick_tgt();
    case ($urandom_range(0, 3))
      0: return 32'h800;
      1: return 32'h900;
      2: return 32'hA00;
      default: return rand_pc() + 32'd4;
    endcase
  endfunction

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        tk;
    logic        pr;
    logic [31:0] pt;
    logic [31:0] tg;
    logic        efault;
    logic [31:0] eredir;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [8];
    bit   t3_pred [4];
    logic rp;
    logic [31:0] rt;
    int   late;

    vt[0] = '{1'b0, 32'hx, 1'bx, 1'bx, 32'hx, 32'hx, 1'b0, 32'h0};
    vt[1] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h104, 32'h200, 1'b1, 32'h200};
    vt[2] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h104, 32'h200, 1'b0, 32'h0};
    vt[3] = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 32'h200, 1'b1, 32'h104};
    vt[4] = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 32'h200, 1'b0, 32'h0};
    vt[5] = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 32'h300, 1'b1, 32'h300};
    vt[6] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h40, 32'h40, 1'b1, 32'h0};
    vt[7] = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h500, 32'h600, 1'b0, 32'h0};
    t3_pred = '{1'b1, 1'b1, 1'b0, 1'b0};

    pc_if = 32'h100;
    model_reset();
    do_reset();

    // T1: reset state
    #3;
    chk("t1_pred", bp_n, 0); chk("t1_tgt", ta_n, 32'h104); chk("t1_ghr", ghr_g, 0);
    chk("t1_bc", bc_g, 0); chk("t1_mc", mc_g, 0);
    step();

    // T2: allocate and learn 0x100 -> 0x200
    res(32'h100, 1, 0, 32'h104, 32'h200); #3;
    chk("t2_fault1", fault_n, 1); chk("t2_redir1", redir_n, 32'h200);
    step();
    res(32'h100, 1, 1, 32'h200, 32'h200); #3;
    chk("t2_pred2", bp_n, 1); chk("t2_fault2", fault_n, 0);
    step();
    set_idle(); #3;
    chk("t2_pred3", bp_n, 1); chk("t2_tgt3", ta_n, 32'h200);
    chk("t2_bc", bc_n, 2); chk("t2_mc", mc_n, 1);
    step();

    // T3: counter 3 walks down to 0 and saturates
    for (int i = 0; i < 4; i++) begin
      res(32'h100, 0, t3_pred[i], 32'h200, 32'h200); #3;
      chk($sformatf("t3_pred%0d", i), bp_n, t3_pred[i]);
      if (i == 0) begin
        chk("t3_fault", fault_n, 1); chk("t3_redir", redir_n, 32'h104);
      end
      step();
    end
    res(32'h100, 1, 0, 32'h104, 32'h200); cycle();
    set_idle(); #3;
    chk("t3_floor", bp_n, 0);
    step();

    // T4: wrong taken target retrains BTB
    res(32'h208, 1, 0, 32'h20C, 32'h200); cycle();
    res(32'h208, 1, 1, 32'h200, 32'h200); cycle();
    pc_if = 32'h208;
    res(32'h208, 1, 1, 32'h200, 32'h300); #3;
    chk("t4_pred", bp_n, 1); chk("t4_tgt_old", ta_n, 32'h200);
    chk("t4_fault", fault_n, 1); chk("t4_redir", redir_n, 32'h300);
    step();
    set_idle(); #3;
    chk("t4_tgt_new", ta_n, 32'h300);
    step();

    // Fault/redirect vector table
    pc_if = 32'h100;
    for (int i = 0; i < 8; i++) begin
      br_valid = vt[i].valid; mem_pc = vt[i].pc; taken = vt[i].tk; pred_mem = vt[i].pr;
      ptgt = vt[i].pt; tgt = vt[i].tg; ghr_mem = m_ghr[1][7:0];
      #3;
      chk($sformatf("vec%0d_fault_n", i), fault_n, vt[i].efault);
      chk($sformatf("vec%0d_redir_n", i), redir_n, vt[i].eredir);
      chk($sformatf("vec%0d_fault_g", i), fault_g, vt[i].efault);
      chk($sformatf("vec%0d_redir_g", i), redir_g, vt[i].eredir);
      if (vt[i].valid) step();
      else begin @(posedge clk); #1; end
    end
    set_idle();

    // T5: gshare history and alternating-pattern training
    do_reset();
    pc_if = 32'h300;
    res(32'h300, 1, 0, 32'h0, 32'h380); cycle();
    res(32'h300, 0, 0, 32'h0, 32'h380); cycle();
    res(32'h300, 1, 0, 32'h0, 32'h380); cycle();
    set_idle(); #3;
    chk("t5_ghr", ghr_g, 8'h05); chk("t5_ghr_frozen", ghr_n, 0);
    step();
    late = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      br_valid = 1; mem_pc = 32'h300; taken = (i % 2 == 1); pred_mem = bp_g;
      ptgt = ta_g; tgt = 32'h380; ghr_mem = ghr_g;
      #2;
      if (i >= 8 && fault_g) late++;
      step();
    end
    chk("t5_late_mispred", late, 0);

    // Perf counter saturation on the 4-bit instance
    do_reset();
    for (int i = 0; i < 20; i++) begin
      res(32'h500, 1, 1'($urandom_range(0, 1)), 32'h504, 32'h600); cycle();
    end
    pc_if = 32'h500;
    set_idle(); #3;
    chk("sat_bc_n", bc_n, 15); chk("sat_bc_g", bc_g, 20); chk("sat_pred", bp_n, 1);
    step();

    // T6: reset beats a same-cycle Mem update
    rst_n = 0;
    res(32'h500, 1, 1, 32'h600, 32'h600); cycle();
    rst_n = 1; set_idle(); #3;
    chk("t6_pred", bp_n, 0); chk("t6_tgt", ta_n, 32'h504); chk("t6_bc", bc_n, 0);
    chk("t6_mc", mc_g, 0); chk("t6_ghr", ghr_g, 0);
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_n    = ($urandom_range(0, 63) != 0);
      pc_if    = rand_pc();
      br_valid = ($urandom_range(0, 3) != 0);
      mem_pc   = rand_pc();
      taken    = 1'($urandom_range(0, 1));
      m_lookup(1, mem_pc, rp, rt);
      if ($urandom_range(0, 1) != 0) begin
        pred_mem = rp; ptgt = rt;
      end else begin
        pred_mem = 1'($urandom_range(0, 1)); ptgt = pick_tgt();
      end
      tgt     = pick_tgt();
      ghr_mem = ($urandom_range(0, 3) != 0) ? m_ghr[1][7:0] : 8'($urandom_range(0, 255));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
